pattern_count_engine: RTL and testbench
=======================================

// Module: pattern_count_engine
// PURPOSE
//  Hardware responder for the program-3 req/done protocol. It computes the three pattern-search results in dedicated logic.
//  On req it reads the 32-byte message (dm[0..31]) and the 5-bit pattern (dm[32][4:0]).
//  It then writes the within-byte count, the bytes-with-match count and the byte-crossing count to dm[33], dm[34] and dm[35].
//  It sits beside data memory as an alternate bus master. It gives a golden hardware result for checking processor runs.
// PARAMETERS
//  ADDR_W     8   data-memory address width
//  STR_BYTES  32  message length in bytes (byte 0 = most-significant byte of the bit string)
//  PAT_ADDR   32  address of the pattern byte; pattern = dm[PAT_ADDR][4:0]
//  OUT_ADDR   33  first result address; results go to OUT_ADDR, OUT_ADDR+1, OUT_ADDR+2
// PORTS
//  clk         in   1       clock, all state updates on rising edge
//  reset       in   1       asynchronous, active-high reset
//  req         in   1       start request, sampled on clk
//  done        out  1       results written; held high until the next accepted req
//  busy        out  1       high from the first cycle after req acceptance until done rises
//  dm_addr     out  ADDR_W  data-memory address
//  dm_rd_data  in   8       combinational read data for dm_addr (valid in the same cycle)
//  dm_wr_en    out  1       synchronous write enable
//  dm_wr_data  out  8       write data
// BEHAVIOUR
//  Reset values: done=0, busy=0, dm_wr_en=0, dm_addr=0, dm_wr_data=0, all counters=0, state=IDLE.
//  FSM: IDLE -> LOAD_PAT -> SCAN(x32) -> WR_B -> WR_O -> WR_S -> DONE.
//  - IDLE / DONE: if req=1 at an edge, go to LOAD_PAT and clear ctb/cto/cts/prev. done falls on that edge.
//  - LOAD_PAT: dm_addr=PAT_ADDR; latch pat=dm_rd_data[4:0]; next state SCAN with idx=0.
//  - SCAN: dm_addr=idx; byte b=dm_rd_data.
//    - ctb += number of matches among b[4:0], b[5:1], b[6:2], b[7:3] (0..4).
//    - cto += 1 if that number is nonzero.
//    - cts += same within-byte number. If idx>0, cts also adds crossing matches among
//      {p[3:0],b[7]}, {p[2:0],b[7:6]}, {p[1:0],b[7:5]}, {p[0],b[7:4]}, where p = previous byte.
//    - Latch p=b. idx==STR_BYTES-1 -> WR_B, else idx++.
//  - WR_B / WR_O / WR_S: dm_wr_en=1, dm_addr=OUT_ADDR+0/1/2, dm_wr_data=ctb/cto/cts.
//  - dm_wr_en=0 in every other state.
//  Widths: 8-bit counters, no saturation needed (max ctb=128, cto=32, cts=252).
//  Latency: req sampled at edge E0; writes commit at E34, E35, E36; done=1 after E36. Total 36 cycles.
//  req while busy (LOAD_PAT..WR_S) is ignored; there is no queuing.
//  req held high across DONE restarts immediately; done stays high for exactly one cycle.
//  Reset mid-run: async return to IDLE; no partial result writes, no further writes; done=0.
//  Byte 0 has no predecessor, so crossing matches are never counted before byte 0 (no wrap-around byte 31->0).
// STRUCTURE
//  pattern_count_pkg:
//   - typedef enum logic [2:0] pc_state_t {IDLE, LOAD_PAT, SCAN, WR_B, WR_O, WR_S, DONE}
//   - localparams for the default addresses
//   - function popcount4
//  Sub-module pat_window_match (combinational) computes the match counts for one byte.
//   - Inputs: pat[4:0], cur[7:0], prev[3:0], prev_vld.
//   - Outputs: in_cnt[2:0] (0..4), cross_cnt[2:0] (0..4).
//   - Instantiated once in pattern_count_engine, which holds the FSM, counters and bus muxing.
// TESTING
//  Bench models a 256x8 memory with combinational read. It checks dm[33..35] after done.
//  T1: all bytes 0x00, dm[32]=0x00 -> dm[33]=128, dm[34]=32, dm[35]=252; done exactly 36 cycles after req edge.
//  T2: all bytes 0x55, dm[32]=0x15 (10101) -> dm[33]=64, dm[34]=32, dm[35]=126.
//  T3: all bytes 0xFF, dm[32]=0x00 -> 0, 0, 0.
//  T4: byte5=0xF8, others 0x00, dm[32]=0x1F -> 1, 1, 1.
//  T5: byte0=0x03, byte1=0xE0, others 0x00, dm[32]=0x1F -> 0, 0, 1 (crossing-only match).
//  T6: assert reset at cycle 10 of a run -> no writes to dm[33..35], done=0.
//      Then req again -> correct T1 results; a req pulse at cycle 5 of that run is ignored (single run, 36-cycle latency).

Source files
------------

// File: rtl/pattern_count_pkg.sv
// pattern_count_pkg: shared state encoding, default addresses and match-count helper
package pattern_count_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_PAT, SCAN, WR_B, WR_O, WR_S, DONE} pc_state_t;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_STR_BYTES = 32;
  localparam int DEF_PAT_ADDR  = 32;
  localparam int DEF_OUT_ADDR  = 33;
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction
endpackage

// File: rtl/pat_window_match.sv
// pat_window_match: counts 5-bit pattern hits inside one byte and across its boundary with the previous byte
module pat_window_match
  import pattern_count_pkg::*;
(
  input  logic [4:0] pat,
  input  logic [7:0] cur,
  input  logic [3:0] prev,
  input  logic       prev_vld,
  output logic [2:0] in_cnt,
  output logic [2:0] cross_cnt
);
  // windows fully inside the byte, then windows straddling prev|cur
  always_comb begin
    in_cnt    = popcount4({cur[4:0] == pat, cur[5:1] == pat, cur[6:2] == pat, cur[7:3] == pat});
    cross_cnt = prev_vld ? popcount4({{prev[3:0], cur[7]} == pat, {prev[2:0], cur[7:6]} == pat,
                                      {prev[1:0], cur[7:5]} == pat, {prev[0], cur[7:4]} == pat}) : 3'd0;
  end
endmodule

// File: rtl/pattern_count_engine.sv
// pattern_count_engine: bus-master that scans a message in data memory and writes three pattern counts back
module pattern_count_engine
  import pattern_count_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int STR_BYTES = DEF_STR_BYTES,
  parameter int PAT_ADDR  = DEF_PAT_ADDR,
  parameter int OUT_ADDR  = DEF_OUT_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] dm_addr,
  input  logic [7:0]        dm_rd_data,
  output logic              dm_wr_en,
  output logic [7:0]        dm_wr_data
);
  pc_state_t         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [4:0]        pat_q, pat_d;
  logic [3:0]        prev_q, prev_d;
  logic [7:0]        ctb_q, ctb_d, cto_q, cto_d, cts_q, cts_d;
  logic [2:0]        in_cnt, cross_cnt;

  pat_window_match u_match (
    .pat      (pat_q),
    .cur      (dm_rd_data),
    .prev     (prev_q),
    .prev_vld (idx_q != '0),
    .in_cnt   (in_cnt),
    .cross_cnt(cross_cnt)
  );

  assign done = state_q == DONE;
  assign busy = state_q != IDLE && state_q != DONE;

  // sequencing, counter accumulation and memory bus drive
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pat_d      = pat_q;
    prev_d     = prev_q;
    ctb_d      = ctb_q;
    cto_d      = cto_q;
    cts_d      = cts_q;
    dm_addr    = '0;
    dm_wr_en   = 1'b0;
    dm_wr_data = '0;
    case (state_q)
      IDLE, DONE: if (req) begin
        state_d = LOAD_PAT;
        ctb_d   = '0;
        cto_d   = '0;
        cts_d   = '0;
        prev_d  = '0;
      end
      LOAD_PAT: begin
        dm_addr = ADDR_W'(PAT_ADDR);
        pat_d   = dm_rd_data[4:0];
        idx_d   = '0;
        state_d = SCAN;
      end
      SCAN: begin
        dm_addr = idx_q;
        ctb_d   = ctb_q + 8'(in_cnt);
        cto_d   = cto_q + 8'(in_cnt != 3'd0);
        cts_d   = cts_q + 8'(in_cnt) + 8'(cross_cnt);
        prev_d  = dm_rd_data[3:0];
        idx_d   = idx_q + 1'b1;
        state_d = idx_q == ADDR_W'(STR_BYTES - 1) ? WR_B : SCAN;
      end
      WR_B: begin
        dm_wr_en   = 1'b1;
        dm_addr    = ADDR_W'(OUT_ADDR);
        dm_wr_data = ctb_q;
        state_d    = WR_O;
      end
      WR_O: begin
        dm_wr_en   = 1'b1;
        dm_addr    = ADDR_W'(OUT_ADDR + 1);
        dm_wr_data = cto_q;
        state_d    = WR_S;
      end
      WR_S: begin
        dm_wr_en   = 1'b1;
        dm_addr    = ADDR_W'(OUT_ADDR + 2);
        dm_wr_data = cts_q;
        state_d    = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers, async clear returns to IDLE with zeroed counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pat_q   <= '0;
      prev_q  <= '0;
      ctb_q   <= '0;
      cto_q   <= '0;
      cts_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      prev_q  <= prev_d;
      ctb_q   <= ctb_d;
      cto_q   <= cto_d;
      cts_q   <= cts_d;
    end
  end
endmodule

// File: tb/tb_pattern_count_engine.sv
// tb_pattern_count_engine: scoreboard bench with directed pattern-search vectors
module tb_pattern_count_engine;
  typedef struct {
    int ctb;
    int cto;
    int cts;
    int lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic       done, busy, dm_wr_en;
  logic [7:0] dm_addr, dm_rd_data, dm_wr_data;
  logic [7:0] img [256];
  logic [7:0] res [256];
  logic       clr = 1'b0;
  logic       done_p = 1'b0;
  int         wr_hits = 0;
  int         cyc = 0;
  int         e0 = 0;
  int         n_vec = 0;
  int         n_err = 0;
  exp_t       sb [$];

  pattern_count_engine dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .busy      (busy),
    .dm_addr   (dm_addr),
    .dm_rd_data(dm_rd_data),
    .dm_wr_en  (dm_wr_en),
    .dm_wr_data(dm_wr_data)
  );

  always #5 clk = ~clk;
  assign dm_rd_data = img[dm_addr];

  always @(posedge clk) cyc <= cyc + 1;

  // result memory: only the DUT writes it; clr restores sentinels on the result bytes
  always @(posedge clk) begin
    if (clr) begin
      res[33] <= 8'hAA;
      res[34] <= 8'hAA;
      res[35] <= 8'hAA;
      wr_hits <= 0;
    end else if (dm_wr_en) begin
      res[dm_addr] <= dm_wr_data;
      wr_hits      <= wr_hits + 1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // monitor: every rising done pops one expectation and checks memory and latency
  always @(negedge clk) begin
    done_p <= done;
    if (done && !done_p) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("dm33_ctb", int'(res[33]), e.ctb);
        chk("dm34_cto", int'(res[34]), e.cto);
        chk("dm35_cts", int'(res[35]), e.cts);
        if (e.lat != 0) chk("latency", cyc - e0, e.lat);
      end
    end
  end

  task automatic load(input logic [7:0] fill, input logic [7:0] pat);
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    for (int i = 0; i < 32; i++) img[i] = fill;
    img[32] = pat;
  endtask

  task automatic clear_res();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  task automatic start();
    @(negedge clk) req = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    @(negedge clk) req = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int k = 0;
    while (!done && k < max) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic run(input int ctb, input int cto, input int cts);
    clear_res();
    sb.push_back('{ctb, cto, cts, 36});
    start();
    wait_done(60);
    @(negedge clk);
    chk("write_count", wr_hits, 3);
  endtask

  initial begin
    load(8'h00, 8'h00);
    repeat (2) @(negedge clk);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr_en", int'(dm_wr_en), 0);
    chk("rst_addr", int'(dm_addr), 0);
    chk("rst_wr_data", int'(dm_wr_data), 0);
    reset = 1'b0;
    // T1 all zero, pattern zero
    load(8'h00, 8'h00);
    run(128, 32, 252);
    // T2 alternating bits, pattern 10101
    load(8'h55, 8'h15);
    run(64, 32, 126);
    // T3 all ones, pattern zero
    load(8'hFF, 8'h00);
    run(0, 0, 0);
    // T4 single in-byte match at byte 5
    load(8'h00, 8'h1F);
    img[5] = 8'hF8;
    run(1, 1, 1);
    // T5 match only across bytes 0/1
    load(8'h00, 8'h1F);
    img[0] = 8'h03;
    img[1] = 8'hE0;
    run(0, 0, 1);
    // T6 reset mid-run, then a clean run with an ignored req pulse
    load(8'h00, 8'h00);
    clear_res();
    start();
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_done", int'(done), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_wr_en", int'(dm_wr_en), 0);
    chk("abort_addr", int'(dm_addr), 0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_writes", wr_hits, 0);
    chk("abort_dm33", int'(res[33]), 8'hAA);
    chk("abort_dm35", int'(res[35]), 8'hAA);
    chk("abort_done_late", int'(done), 0);
    sb.push_back('{128, 32, 252, 36});
    start();
    repeat (4) @(negedge clk);
    req = 1'b1;
    @(negedge clk) req = 1'b0;
    wait_done(60);
    @(negedge clk);
    chk("rerun_writes", wr_hits, 3);
    // T7 req held through DONE restarts at once; done is a single-cycle pulse
    load(8'h55, 8'h15);
    clear_res();
    sb.push_back('{64, 32, 126, 36});
    sb.push_back('{64, 32, 126, 0});
    @(negedge clk) req = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    @(negedge clk);
    wait_done(60);
    @(negedge clk);
    chk("held_done_pulse", int'(done), 0);
    chk("held_busy", int'(busy), 1);
    wait_done(60);
    req = 1'b0;
    @(negedge clk);
    chk("done_held", int'(done), 1);
    chk("held_writes", wr_hits, 6);
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
